// File: rtl/reg_file_mp_if.sv
// rtl/reg_file_mp_if.sv - register file read/write/allocate bus
// Purpose: groups the decode-side read and allocate signals and the two
//          writeback lanes of reg_file_mp into one bundle.
// Ports (signals):
//   rs1_addr, rs2_addr   read addresses            (master -> slave)
//   rs1_data, rs2_data   read data                 (slave -> master)
//   rs1_busy, rs2_busy   scoreboard status         (slave -> master)
//   we0/wa0/wd0          writeback lane 0          (master -> slave)
//   we1/wa1/wd1          writeback lane 1, younger (master -> slave)
//   alloc, alloc_addr    mark register busy        (master -> slave)
interface reg_file_mp_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
);
   localparam int AW = $clog2(NREGS);

   logic [AW-1:0]   rs1_addr;
   logic [AW-1:0]   rs2_addr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            rs1_busy;
   logic            rs2_busy;
   logic            we0;
   logic [AW-1:0]   wa0;
   logic [XLEN-1:0] wd0;
   logic            we1;
   logic [AW-1:0]   wa1;
   logic [XLEN-1:0] wd1;
   logic            alloc;
   logic [AW-1:0]   alloc_addr;

   modport master (
      output rs1_addr, rs2_addr, we0, wa0, wd0, we1, wa1, wd1, alloc, alloc_addr,
      input  rs1_data, rs2_data, rs1_busy, rs2_busy
   );

   modport slave (
      input  rs1_addr, rs2_addr, we0, wa0, wd0, we1, wa1, wd1, alloc, alloc_addr,
      output rs1_data, rs2_data, rs1_busy, rs2_busy
   );
endinterface

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port integer register file with busy scoreboard
// Purpose: NREGS x XLEN register file with two combinational read ports,
//          two write lanes (lane 1 wins on collision), optional write-first
//          bypass and a per-register busy bit for in-flight producers.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears contents and busy bits
//   bus    reg_file_mp_if.slave: read ports, write lanes, allocate
// The interface instance must use the same XLEN/NREGS as this module.
module reg_file_mp #(
   parameter int XLEN    = 32,
   parameter int NREGS   = 32,
   parameter int ZERO_R0 = 1,
   parameter int BYPASS  = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   reg_file_mp_if.slave bus
);
   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;

   // One-hot per-register decode of both lanes and the allocate port.
   // clr is taken before the r0 mask; r0 can never be busy when ZERO_R0
   // is set, so clearing it is harmless.
   logic [NREGS-1:0] wr0, wr1, set, clr;

   always_comb begin
      wr0 = '0;
      wr1 = '0;
      set = '0;
      for (int r = 0; r < NREGS; r++) begin
         wr0[r] = bus.we0 && (bus.wa0 == AW'(r));
         wr1[r] = bus.we1 && (bus.wa1 == AW'(r));
         set[r] = bus.alloc && (bus.alloc_addr == AW'(r));
      end
      clr = wr0 | wr1;
      if (ZERO_R0 != 0) begin
         wr0[0] = 1'b0;
         wr1[0] = 1'b0;
         set[0] = 1'b0;
      end
   end

   // Set has priority over clear: a freshly issued producer supersedes the
   // one retiring in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) regs[r] <= '0;
         busy <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            if (wr1[r])      regs[r] <= bus.wd1;
            else if (wr0[r]) regs[r] <= bus.wd0;
         end
         busy <= set | (busy & ~clr);
      end
   end

   logic [AW-1:0]   raddr [2];
   logic [XLEN-1:0] rdata [2];
   logic            rbusy [2];

   assign raddr[0] = bus.rs1_addr;
   assign raddr[1] = bus.rs2_addr;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdata[p] = regs[raddr[p]];
         rbusy[p] = busy[raddr[p]];
         if (BYPASS != 0) begin
            // Younger lane first, matching the write priority.
            if (wr1[raddr[p]])      rdata[p] = bus.wd1;
            else if (wr0[raddr[p]]) rdata[p] = bus.wd0;
            if (clr[raddr[p]])      rbusy[p] = 1'b0;
         end
         // r0 is forced last so a bypassed write to it never leaks through.
         if ((ZERO_R0 != 0) && (raddr[p] == '0)) begin
            rdata[p] = '0;
            rbusy[p] = 1'b0;
         end
      end
   end

   assign bus.rs1_data = rdata[0];
   assign bus.rs2_data = rdata[1];
   assign bus.rs1_busy = rbusy[0];
   assign bus.rs2_busy = rbusy[1];
endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - scoreboard bench for reg_file_mp
module tb_reg_file_mp;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  rs1_addr, rs2_addr, wa0, wa1, alloc_addr;
   logic [63:0] wd0, wd1;
   logic        we0, we1, alloc;

   always #5 clk = ~clk;

   // dut 0: 32x32 ZERO_R0=1 BYPASS=1; dut 1: 16x64 ZERO_R0=1 BYPASS=1;
   // dut 2: 16x64 ZERO_R0=0 BYPASS=0. All share one stimulus.
   reg_file_mp_if #(.XLEN(32), .NREGS(32)) a_if ();
   reg_file_mp_if #(.XLEN(64), .NREGS(16)) s_if ();
   reg_file_mp_if #(.XLEN(64), .NREGS(16)) n_if ();

   assign a_if.rs1_addr = rs1_addr;       assign a_if.rs2_addr = rs2_addr;
   assign a_if.we0 = we0;                 assign a_if.wa0 = wa0;
   assign a_if.wd0 = wd0[31:0];           assign a_if.we1 = we1;
   assign a_if.wa1 = wa1;                 assign a_if.wd1 = wd1[31:0];
   assign a_if.alloc = alloc;             assign a_if.alloc_addr = alloc_addr;

   assign s_if.rs1_addr = rs1_addr[3:0];  assign s_if.rs2_addr = rs2_addr[3:0];
   assign s_if.we0 = we0;                 assign s_if.wa0 = wa0[3:0];
   assign s_if.wd0 = wd0;                 assign s_if.we1 = we1;
   assign s_if.wa1 = wa1[3:0];            assign s_if.wd1 = wd1;
   assign s_if.alloc = alloc;             assign s_if.alloc_addr = alloc_addr[3:0];

   assign n_if.rs1_addr = rs1_addr[3:0];  assign n_if.rs2_addr = rs2_addr[3:0];
   assign n_if.we0 = we0;                 assign n_if.wa0 = wa0[3:0];
   assign n_if.wd0 = wd0;                 assign n_if.we1 = we1;
   assign n_if.wa1 = wa1[3:0];            assign n_if.wd1 = wd1;
   assign n_if.alloc = alloc;             assign n_if.alloc_addr = alloc_addr[3:0];

   reg_file_mp #(.XLEN(32), .NREGS(32), .ZERO_R0(1), .BYPASS(1))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
   reg_file_mp #(.XLEN(64), .NREGS(16), .ZERO_R0(1), .BYPASS(1))
      dut_s (.clk(clk), .rst_n(rst_n), .bus(s_if));
   reg_file_mp #(.XLEN(64), .NREGS(16), .ZERO_R0(0), .BYPASS(0))
      dut_n (.clk(clk), .rst_n(rst_n), .bus(n_if));

   // o[dut][sel]: sel 0 rs1_data, 1 rs2_data, 2 rs1_busy, 3 rs2_busy
   wire [63:0] o [3][4];
   assign o[0][0] = {32'b0, a_if.rs1_data};  assign o[0][1] = {32'b0, a_if.rs2_data};
   assign o[0][2] = {63'b0, a_if.rs1_busy};  assign o[0][3] = {63'b0, a_if.rs2_busy};
   assign o[1][0] = s_if.rs1_data;           assign o[1][1] = s_if.rs2_data;
   assign o[1][2] = {63'b0, s_if.rs1_busy};  assign o[1][3] = {63'b0, s_if.rs2_busy};
   assign o[2][0] = n_if.rs1_data;           assign o[2][1] = n_if.rs2_data;
   assign o[2][2] = {63'b0, n_if.rs1_busy};  assign o[2][3] = {63'b0, n_if.rs2_busy};

   typedef struct {
      string       tag;
      int          dut;
      int          sel;
      logic [63:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference state for the two 16-entry duts (index 1 and 2).
   logic [63:0] m_reg  [3][16];
   logic        m_busy [3][16];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input string tag, input int dut, input int sel, input logic [63:0] val);
      exp_t e;
      e.tag = tag; e.dut = dut; e.sel = sel; e.val = val;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check($sformatf("%s/dut%0d/sel%0d", e.tag, e.dut, e.sel), o[e.dut][e.sel], e.val);
      end
   endtask

   task automatic step();
      @(negedge clk);
      drain();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we0 = 0; we1 = 0; alloc = 0;
      wa0 = 0; wa1 = 0; alloc_addr = 0; wd0 = 0; wd1 = 0;
   endtask

   function automatic logic [63:0] exp_data(input int k, input logic [3:0] a);
      if (k == 1 && a == 0) return 64'd0;
      if (k == 1) begin
         if (we1 && wa1[3:0] == a) return wd1;
         if (we0 && wa0[3:0] == a) return wd0;
      end
      return m_reg[k][a];
   endfunction

   function automatic logic exp_busy(input int k, input logic [3:0] a);
      if (k == 1 && a == 0) return 1'b0;
      if (k == 1 && ((we0 && wa0[3:0] == a) || (we1 && wa1[3:0] == a))) return 1'b0;
      return m_busy[k][a];
   endfunction

   task automatic model_clock();
      logic cl, st, z;
      for (int k = 1; k < 3; k++) begin
         z = (k == 1);
         for (int r = 0; r < 16; r++) begin
            cl = (we0 && wa0[3:0] == 4'(r)) || (we1 && wa1[3:0] == 4'(r));
            st = alloc && alloc_addr[3:0] == 4'(r) && !(z && r == 0);
            m_busy[k][r] = st | (m_busy[k][r] & ~cl);
         end
         if (we0 && !(z && wa0[3:0] == 0)) m_reg[k][wa0[3:0]] = wd0;
         if (we1 && !(z && wa1[3:0] == 0)) m_reg[k][wa1[3:0]] = wd1;
      end
   endtask

   initial begin
      rst_n = 0; rs1_addr = 0; rs2_addr = 0;
      idle();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;

      // Reset contents on every address of both ports
      for (int a = 0; a < 32; a++) begin
         rs1_addr = 5'(a); rs2_addr = 5'(31 - a);
         for (int d = 0; d < 3; d++)
            for (int s = 0; s < 4; s++) push("rst", d, s, 64'd0);
         step();
      end

      // Plain write, bypass on dut0, delayed visibility on dut2
      rs1_addr = 5; rs2_addr = 5; we0 = 1; wa0 = 5; wd0 = 64'hDEADBEEF;
      push("wr5_same", 0, 0, 64'hDEADBEEF); push("wr5_same", 2, 0, 64'd0);
      step();
      idle();
      push("wr5_next", 0, 0, 64'hDEADBEEF); push("wr5_next", 2, 0, 64'hDEADBEEF);
      step();

      // Write to r0
      rs1_addr = 0; we0 = 1; wa0 = 0; wd0 = 64'h1234;
      push("r0_same", 0, 0, 64'd0);
      step();
      idle();
      push("r0_next", 0, 0, 64'd0); push("r0_next", 2, 0, 64'h1234);
      step();

      // Dual write collision, lane 1 wins
      rs1_addr = 7; we0 = 1; we1 = 1; wa0 = 7; wa1 = 7; wd0 = 64'h11; wd1 = 64'h22;
      push("coll_same", 0, 0, 64'h22);
      step();
      idle();
      push("coll_next", 0, 0, 64'h22); push("coll_next", 2, 0, 64'h22);
      step();

      // Lane 1 bypass to rs2
      rs2_addr = 9; we1 = 1; wa1 = 9; wd1 = 64'hA5A5A5A5;
      push("byp_same", 0, 1, 64'hA5A5A5A5); push("byp_same", 2, 1, 64'd0);
      step();
      idle();
      push("byp_next", 0, 1, 64'hA5A5A5A5); push("byp_next", 2, 1, 64'hA5A5A5A5);
      step();

      // Scoreboard: alloc, then writeback
      rs1_addr = 3; alloc = 1; alloc_addr = 3;
      push("alloc_same", 0, 2, 64'd0); push("alloc_same", 2, 2, 64'd0);
      step();
      idle();
      push("alloc_next", 0, 2, 64'd1); push("alloc_next", 2, 2, 64'd1);
      step();
      we0 = 1; wa0 = 3; wd0 = 64'h33;
      push("wb_same", 0, 2, 64'd0); push("wb_same", 2, 2, 64'd1);
      step();
      idle();
      push("wb_next", 0, 2, 64'd0); push("wb_next", 2, 2, 64'd0);
      step();

      // Alloc and writeback together: busy stays set
      alloc = 1; alloc_addr = 3; we0 = 1; wa0 = 3; wd0 = 64'h44;
      step();
      idle();
      push("aw_next", 0, 2, 64'd1); push("aw_next", 2, 2, 64'd1);
      push("aw_data", 0, 0, 64'h44);
      step();

      // Alloc to r0
      rs1_addr = 0; alloc = 1; alloc_addr = 0;
      step();
      idle();
      push("alloc0", 0, 2, 64'd0); push("alloc0", 2, 2, 64'd1);
      push("alloc0_d", 0, 0, 64'd0); push("alloc0_d", 2, 0, 64'h1234);
      step();

      // Asynchronous reset mid-cycle with busy and data pending
      rs1_addr = 5; rs2_addr = 3;
      #1;
      push("pre_rst", 0, 0, 64'hDEADBEEF); push("pre_rst", 0, 3, 64'd1);
      drain();
      #1 rst_n = 0;
      #1;
      for (int d = 0; d < 3; d += 2)
         for (int s = 0; s < 4; s++) push("async_rst", d, s, 64'd0);
      drain();
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;

      // Random stress against the reference model (duts 1 and 2)
      for (int k = 0; k < 3; k++)
         for (int r = 0; r < 16; r++) begin
            m_reg[k][r] = '0;
            m_busy[k][r] = 1'b0;
         end
      for (int i = 0; i < 10000; i++) begin
         we0 = 1'($urandom);
         we1 = 1'($urandom);
         alloc = 1'($urandom);
         wa0 = 5'($urandom_range(0, 15));
         wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 15));
         alloc_addr = ($urandom_range(0, 3) == 0) ? wa1 : 5'($urandom_range(0, 15));
         wd0 = {$urandom, $urandom};
         wd1 = {$urandom, $urandom};
         rs1_addr = ($urandom_range(0, 2) == 0) ? wa1 : 5'($urandom_range(0, 15));
         rs2_addr = ($urandom_range(0, 2) == 0) ? wa0 : 5'($urandom_range(0, 15));
         for (int k = 1; k < 3; k++) begin
            push("rnd", k, 0, exp_data(k, rs1_addr[3:0]));
            push("rnd", k, 1, exp_data(k, rs2_addr[3:0]));
            push("rnd", k, 2, {63'b0, exp_busy(k, rs1_addr[3:0])});
            push("rnd", k, 3, {63'b0, exp_busy(k, rs2_addr[3:0])});
         end
         @(negedge clk);
         drain();
         @(posedge clk);
         model_clock();
         #1;
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
